// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stack_pkg
//  Purpose  : Shared constants and command encoding for the LIFO stack unit.
//  Revision : 1.0  initial release
// ============================================================================
package stack_pkg;

  localparam int WORD_W      = 8;
  localparam int STACK_DEPTH = 8;

  // Command encoding, formed as {push, pop}
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : stack_unit
//  Purpose  : LIFO stack with top/next-of-stack views, occupancy count and
//             sticky overflow/underflow flags. One command per clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module stack_unit
  import stack_pkg::*;
#(
  parameter int  WIDTH = WORD_W,
  parameter int  DEPTH = STACK_DEPTH,
  localparam int PW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [PW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  // Storage index width; the pointer needs one more code (DEPTH itself)
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] SP_MAX = PW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp;
  logic [PW-1:0]    sp_m1;
  logic [PW-1:0]    sp_m2;
  logic [PW-1:0]    sp_nxt;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic             ovf_set;
  logic             unf_set;
  logic             is_empty;
  logic             is_full;
  stack_op_e        op;

  assign op       = stack_op_e'({push, pop});
  assign is_empty = (sp == '0);
  assign is_full  = (sp == SP_MAX);
  assign sp_m1    = sp - PW'(1);
  assign sp_m2    = sp - PW'(2);

  // Command decode: next pointer, write strobe/index and error events
  always_comb begin
    sp_nxt  = sp;
    wr_en   = 1'b0;
    wr_idx  = sp[AW-1:0];
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        if (is_full) begin
          ovf_set = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wr_idx = sp[AW-1:0];
          sp_nxt = sp + PW'(1);
        end
      end
      OP_POP: begin
        if (is_empty) begin
          unf_set = 1'b1;
        end else begin
          sp_nxt = sp_m1;
        end
      end
      OP_REPLACE: begin
        // Overwrite the top in place; legal even when full
        if (is_empty) begin
          unf_set = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wr_idx = sp_m1[AW-1:0];
        end
      end
      default: begin
        sp_nxt = sp;
      end
    endcase
  end

  // Pointer and sticky error flags; a same-cycle error beats clr_err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_nxt;
      overflow  <= (overflow  & ~clr_err) | ovf_set;
      underflow <= (underflow & ~clr_err) | unf_set;
    end
  end

  // Storage array; popped data is intentionally left in place
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= din;
    end
  end

  // Output decodes of the registered state
  always_comb begin
    tos   = is_empty ? '0 : mem[sp_m1[AW-1:0]];
    nos   = (sp > PW'(1)) ? mem[sp_m2[AW-1:0]] : '0;
    count = sp;
    empty = is_empty;
    full  = is_full;
  end

endmodule : stack_unit
`default_nettype wire

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- LIFO responder to the controller's push/pop command interface; presents top-of-stack (tos) for branch decisions and operand fetch.
- Sits inside the datapath between the memory-data/ALU result mux and the A/B operand registers.
- Single-cycle command acceptance; tos is valid immediately after the accepting edge.
- Detects overflow/underflow with sticky flags.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of stack entries (at least 2).
- PW, $clog2(DEPTH+1), pointer/count width (localparam, derived).

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  push din this cycle.
- pop  input  1  pop top entry this cycle.
- din  input  WIDTH  data to push.
- clr_err  input  1  clears sticky error flags.
- tos  output  WIDTH  current top entry; 0 when empty.
- nos  output  WIDTH  entry below top; 0 when count < 2.
- count  output  PW  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (asynchronous, active-high): sp=0, all storage entries=0, overflow=0, underflow=0.
  - Outputs then read tos=0, nos=0, count=0, empty=1, full=0.
  - Reset asserted mid-operation aborts the command in flight; no partial write survives.
- State: storage array mem[0..DEPTH-1] and pointer sp (equal to count). All are flops; outputs are combinational decodes of this registered state.
  - tos = mem[sp-1] when sp>0, else 0.
  - nos = mem[sp-2] when sp>1, else 0.
- Command decode per rising edge, op = {push,pop}:
  - 00 NOP: no change.
  - 10 PUSH, not full: mem[sp]<=din; sp<=sp+1.
  - 10 PUSH, full: storage and sp unchanged; overflow<=1.
  - 01 POP, not empty: sp<=sp-1. The popped entry's data is not cleared.
  - 01 POP, empty: no change; underflow<=1.
  - 11 REPLACE, not empty: mem[sp-1]<=din; sp unchanged. Legal when full; no overflow.
  - 11 REPLACE, empty: no change; underflow<=1.
- Latency: tos/nos/count reflect a command on the cycle after its accepting edge; there are no wait states.
- Sticky flags:
  - Set only by the error conditions above.
  - clr_err=1 clears both flags at the edge.
  - An error in the same cycle as clr_err wins: that flag reads 1.
- Pointer never wraps: sp saturates in range 0..DEPTH. All writes index within 0..DEPTH-1.
- din is sampled only at the accepting edge; X on din is permitted when push=0.

Decomposition:
- Package stack_pkg holds:
  - WORD_W=8 and STACK_DEPTH=8 constants.
  - typedef enum logic [1:0] stack_op_e {OP_NOP=2'b00, OP_POP=2'b01, OP_PUSH=2'b10, OP_REPLACE=2'b11}, formed as {push,pop}.
- Single module; no sub-module. Pointer and flag logic are too small to justify one.

Test Plan:
- After reset: push 8'h11, 8'h22, 8'h33 on consecutive cycles -> count=3, tos=8'h33, nos=8'h22, empty=0, full=0.
- Push 9 values 1..9 with DEPTH=8 -> after the 8th push full=1, tos=8. The 9th push leaves tos=8, count=8, and sets overflow=1. Then assert clr_err alone -> overflow=0.
- From count=2 (tos=8'hA5, nos=8'h5A): push=1, pop=1, din=8'hC3 -> tos=8'hC3, nos=8'h5A, count=2.
- From empty: pop -> underflow=1, count=0, tos=0. Same-cycle pop + clr_err when empty -> underflow stays 1.
- Fill 3 entries, pop 3, then pop again -> tos after each pop steps to nos, count reaches 0, and the 4th pop sets underflow.
- Assert rst asynchronously (mid-cycle) with count=5 while a push is pending -> outputs immediately read count=0, tos=0, empty=1, flags=0. After release, a push of 8'h7E gives tos=8'h7E, count=1.
